// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Control-word field layout shared by the control pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int CTRL_W          = 14;

    localparam int PCSRC_LSB       = 0;
    localparam int PCSRC_W         = 2;
    localparam int ALUSRC_B_BIT    = 2;
    localparam int ALUSRC_A_LSB    = 3;
    localparam int ALUSRC_A_W      = 2;
    localparam int ALUCONTROL_LSB  = 5;
    localparam int ALUCONTROL_W    = 5;
    localparam int MEMWRITE_BIT    = 10;
    localparam int RESULTSRC_LSB   = 11;
    localparam int RESULTSRC_W     = 2;
    localparam int REGWRITE_BIT    = 13;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic [4:0] alucontrol;
        logic [1:0] alusrc_a;
        logic       alusrc_b;
        logic [1:0] pcsrc;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // A word is architecturally harmless when it writes nothing and does not redirect the PC.
    function automatic logic has_side_effect(input logic [CTRL_W-1:0] w);
        return w[REGWRITE_BIT] | w[MEMWRITE_BIT] | (|w[PCSRC_LSB +: PCSRC_W]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_stage.sv
// ============================================================================
// Module   : pipe_ctrl_stage
// Brief    : One control-word stage register with flush/stall/bubble handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_stall,
    input  logic             i_up_stall,
    input  logic [WIDTH-1:0] i_up_ctrl,
    input  logic             i_up_valid,
    output logic [WIDTH-1:0] o_ctrl,
    output logic             o_valid,
    output logic             o_bubble
);

    logic [WIDTH-1:0] r_ctrl;
    logic             r_valid;

    // Only a genuine stall-split bubble counts; flush and local hold take precedence.
    assign o_bubble = ~i_flush & ~i_stall & i_up_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl  <= BUBBLE;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_ctrl  <= BUBBLE;
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_ctrl  <= r_ctrl;
            r_valid <= r_valid;
        end else if (i_up_stall) begin
            r_ctrl  <= BUBBLE;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= i_up_valid ? i_up_ctrl : BUBBLE;
            r_valid <= i_up_valid;
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_chain.sv
// ============================================================================
// Module   : pipe_ctrl_chain
// Brief    : Multi-stage control-word pipeline with stall checker and bubble counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter int               STAGES = 3,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_ctrl,
    input  logic                    in_valid,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic                    cnt_clr,
    output logic                    in_ready,
    output logic [STAGES*WIDTH-1:0] out_ctrl,
    output logic [STAGES-1:0]       out_valid,
    output logic                    stall_err,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam logic [CNT_W+3:0] c_CNT_MAX = {4'b0, {CNT_W{1'b1}}};

    logic [STAGES-1:0] w_bubble;
    logic [STAGES-1:0] w_up_stall;
    logic              w_illegal;
    logic [3:0]        w_inc;
    logic [CNT_W+3:0]  w_sum;
    logic              r_stall_err;
    logic [CNT_W-1:0]  r_cnt;

    assign in_ready = ~stall[0];

    generate
        if (STAGES > 1) begin : g_multi
            assign w_up_stall = {stall[STAGES-2:0], 1'b0};
            assign w_illegal  = |(stall[STAGES-1:1] & ~stall[STAGES-2:0]);
        end else begin : g_single
            assign w_up_stall = '0;
            assign w_illegal  = 1'b0;
        end
    endgenerate

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            logic [WIDTH-1:0] w_up_ctrl;
            logic             w_up_valid;

            if (g == 0) begin : g_head
                assign w_up_ctrl  = in_ctrl;
                assign w_up_valid = in_valid;
            end else begin : g_body
                assign w_up_ctrl  = out_ctrl[(g-1)*WIDTH +: WIDTH];
                assign w_up_valid = out_valid[g-1];
            end

            pipe_ctrl_stage #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .i_flush    (flush[g]),
                .i_stall    (stall[g]),
                .i_up_stall (w_up_stall[g]),
                .i_up_ctrl  (w_up_ctrl),
                .i_up_valid (w_up_valid),
                .o_ctrl     (out_ctrl[g*WIDTH +: WIDTH]),
                .o_valid    (out_valid[g]),
                .o_bubble   (w_bubble[g])
            );
        end
    endgenerate

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_inc = w_inc + 4'(w_bubble[i]);
        end
    end

    // Widened sum lets saturation be detected without wrap for any CNT_W.
    assign w_sum = {4'b0, r_cnt} + {{CNT_W{1'b0}}, w_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_illegal) begin
                r_stall_err <= 1'b1;
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_sum > c_CNT_MAX) begin
                r_cnt <= {CNT_W{1'b1}};
            end else begin
                r_cnt <= w_sum[CNT_W-1:0];
            end
        end
    end

    assign stall_err  = r_stall_err;
    assign bubble_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_chain.sv
// ============================================================================
// Module   : tb_pipe_ctrl_chain
// Brief    : Directed self-checking bench for pipe_ctrl_chain (3 stages, 8-bit words).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_chain;

    logic        clk;
    logic        rst;
    logic [7:0]  in_ctrl;
    logic        in_valid;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic        cnt_clr;
    logic        in_ready;
    logic [23:0] out_ctrl;
    logic [2:0]  out_valid;
    logic        stall_err;
    logic [3:0]  bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl_chain #(
        .WIDTH  (8),
        .STAGES (3),
        .BUBBLE (8'h00),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ctrl    (in_ctrl),
        .in_valid   (in_valid),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_ready   (in_ready),
        .out_ctrl   (out_ctrl),
        .out_valid  (out_valid),
        .stall_err  (stall_err),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_ctrl  = 8'h00;
        in_valid = 1'b0;
        stall    = 3'b000;
        flush    = 3'b000;
        cnt_clr  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Partially fill, then hit reset between edges.
        in_ctrl = 8'hB1; in_valid = 1'b1; step();
        in_ctrl = 8'hB2; step();
        chk("prefill_valid", 32'(out_valid), 32'h3);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'h0);
        chk("rst_async_ctrl", 32'(out_ctrl), 32'h0);
        chk("rst_cnt", 32'(bubble_cnt), 32'h0);
        chk("rst_err", 32'(stall_err), 32'h0);
        #2;
        rst = 1'b0;

        // Flow: A1..A3 fill the pipe.
        in_ctrl = 8'hA1; in_valid = 1'b1; step();
        chk("fill1_ctrl", 32'(out_ctrl), 32'h0000A1);
        in_ctrl = 8'hA2; step();
        in_ctrl = 8'hA3; step();
        chk("fill_ctrl", 32'(out_ctrl), 32'hA1A2A3);
        chk("fill_valid", 32'(out_valid), 32'h7);

        // Stall split on stage 0 for two edges.
        in_ctrl = 8'hA4; stall = 3'b001;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("stall1_ctrl", 32'(out_ctrl), 32'hA200A3);
        chk("stall1_valid", 32'(out_valid), 32'h5);
        chk("stall1_cnt", 32'(bubble_cnt), 32'h1);
        step();
        chk("stall2_ctrl", 32'(out_ctrl), 32'h0000A3);
        chk("stall2_valid", 32'(out_valid), 32'h1);
        chk("stall2_cnt", 32'(bubble_cnt), 32'h2);
        stall = 3'b000;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("release_ctrl", 32'(out_ctrl), 32'h00A3A4);
        chk("release_valid", 32'(out_valid), 32'h3);

        // Flush beats stall; flushed stage 1 is not a counted bubble.
        in_ctrl = 8'hA5; flush = 3'b011; stall = 3'b001;
        step();
        chk("flush_ctrl", 32'(out_ctrl), 32'hA30000);
        chk("flush_valid", 32'(out_valid), 32'h4);
        chk("flush_cnt", 32'(bubble_cnt), 32'h2);
        flush = 3'b000; stall = 3'b000;

        // Invalid input is masked to the bubble word.
        in_ctrl = 8'hFF; in_valid = 1'b0;
        step();
        chk("mask_ctrl", 32'(out_ctrl), 32'h000000);
        chk("mask_valid", 32'(out_valid), 32'h0);
        chk("mask_err", 32'(stall_err), 32'h0);

        // Illegal stall pattern: stage 1 held while stage 0 advances.
        in_ctrl = 8'hC1; in_valid = 1'b1; stall = 3'b010;
        step();
        chk("illegal_err", 32'(stall_err), 32'h1);
        chk("illegal_ctrl", 32'(out_ctrl), 32'h0000C1);
        chk("illegal_cnt", 32'(bubble_cnt), 32'h3);
        stall = 3'b000; in_valid = 1'b0;
        step();
        chk("err_sticky", 32'(stall_err), 32'h1);

        // Saturation: one counted bubble per edge with stall=011.
        stall = 3'b011;
        for (int i = 0; i < 11; i++) step();
        chk("sat_pre_cnt", 32'(bubble_cnt), 32'hE);
        step();
        chk("sat_cnt", 32'(bubble_cnt), 32'hF);
        for (int i = 0; i < 8; i++) step();
        chk("sat_nowrap", 32'(bubble_cnt), 32'hF);
        chk("sat_err_hold", 32'(stall_err), 32'h1);

        // Clear wins over a same-edge increment.
        stall = 3'b001; cnt_clr = 1'b1;
        step();
        chk("clr_cnt", 32'(bubble_cnt), 32'h0);
        cnt_clr = 1'b0;
        step();
        chk("post_clr_cnt", 32'(bubble_cnt), 32'h1);
        stall = 3'b000;

        rst = 1'b1;
        #1;
        chk("rst_clears_err", 32'(stall_err), 32'h0);
        chk("rst_clears_cnt", 32'(bubble_cnt), 32'h0);
        #2;
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
